// File: rtl/spi_cmd_master.sv
// SPI command master: serialises 10-bit host commands as one ss_n frame on mosi
// and, for read-data commands, collects the 8-bit reply from miso.
module spi_cmd_master #(
  parameter int TURNAROUND = 1,
  parameter int GAP        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid_i,
  input  logic [9:0] cmd_data_i,
  output logic       cmd_ready_o,
  output logic       rd_valid_o,
  output logic [7:0] rd_data_o,
  output logic       busy_o,
  output logic       ss_n_o,
  output logic       mosi_o,
  input  logic       miso_i
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_TURN  = 3'd3;
  localparam logic [2:0] S_RECV  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [3:0] TA_LAST  = 4'(TURNAROUND - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  logic [2:0] state_q, state_d;
  logic [9:0] sreg_q, sreg_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rdd_q, rdd_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       rdy_q, rdy_d;
  logic       rdv_q, rdv_d;
  logic       busy_q;
  logic [7:0] rx_next;

  assign rx_next = {rx_q[6:0], miso_i};

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    rdd_d   = rdd_q;
    ss_n_d  = ss_n_q;
    mosi_d  = mosi_q;
    rdy_d   = rdy_q;
    rdv_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ss_n_d = 1'b1;
        mosi_d = 1'b0;
        rdy_d  = 1'b1;
        if (cmd_valid_i && rdy_q) begin
          state_d = S_START;
          sreg_d  = cmd_data_i;
          ss_n_d  = 1'b0;
          mosi_d  = cmd_data_i[9];
          rdy_d   = 1'b0;
          cnt_d   = 4'd0;
        end
      end
      // the command bit goes out once in START and again as the first SHIFT bit
      S_START: begin
        state_d = S_SHIFT;
        mosi_d  = sreg_q[9];
        cnt_d   = 4'd1;
      end
      S_SHIFT: begin
        if (cnt_q == 4'd10) begin
          mosi_d = 1'b0;
          cnt_d  = 4'd0;
          if (sreg_q[9:8] == 2'b11) begin
            state_d = (TURNAROUND == 0) ? S_RECV : S_TURN;
          end else begin
            state_d = S_GAP;
            ss_n_d  = 1'b1;
          end
        end else begin
          mosi_d = sreg_q[4'd9 - cnt_q];
          cnt_d  = cnt_q + 4'd1;
        end
      end
      S_TURN: begin
        if (cnt_q == TA_LAST) begin
          state_d = S_RECV;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      // last sample goes straight into rd_data so the reply is out as ss_n rises
      S_RECV: begin
        rx_d = rx_next;
        if (cnt_q == 4'd7) begin
          rdd_d   = rx_next;
          rdv_d   = 1'b1;
          state_d = S_GAP;
          ss_n_d  = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
        rdy_d   = 1'b0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      rx_q    <= '0;
      rdd_q   <= '0;
      ss_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      rdy_q   <= 1'b0;
      rdv_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      rdd_q   <= rdd_d;
      ss_n_q  <= ss_n_d;
      mosi_q  <= mosi_d;
      rdy_q   <= rdy_d;
      rdv_q   <= rdv_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign cmd_ready_o = rdy_q;
  assign rd_valid_o  = rdv_q;
  assign rd_data_o   = rdd_q;
  assign busy_o      = busy_q;
  assign ss_n_o      = ss_n_q;
  assign mosi_o      = mosi_q;
endmodule
